// File: rtl/orientation_peak_finder.sv
// Buffers an N_BINS orientation histogram, then scans it circularly for peaks.
// Define PEAK_SECONDARY_EN to emit secondary peaks; otherwise argmax only.
module orientation_peak_finder #(
    parameter int N_BINS    = 36,
    parameter int DATA_W    = 16,
    parameter int IDX_W     = 6,
    parameter int RATIO_NUM = 4,
    parameter int RATIO_DEN = 5
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              idata_en,
    input  logic [DATA_W-1:0] idata,
    output logic              oready,
    output logic              opeak_valid,
    input  logic              ipeak_ready,
    output logic [IDX_W-1:0]  opeak_index,
    output logic [DATA_W-1:0] opeak_value,
    output logic              opeak_primary,
    output logic              odone,
    output logic [IDX_W-1:0]  opeak_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int              PW   = DATA_W + 8;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_BINS - 1);

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_buf [N_BINS];
    logic [IDX_W-1:0]  r_wr_idx;
    logic [IDX_W-1:0]  r_scan;
    logic              r_scan_end;
    logic [IDX_W-1:0]  r_max_idx;
    logic [DATA_W-1:0] r_max_val;
    logic              r_valid;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_val;
    logic              r_pri;
    logic [IDX_W-1:0]  r_count;

    logic              w_accept;
    logic              w_hs;
    logic              w_eval;
    logic [IDX_W-1:0]  w_l_idx;
    logic [IDX_W-1:0]  w_r_idx;
    logic [DATA_W-1:0] w_c;
    logic [DATA_W-1:0] w_l;
    logic [DATA_W-1:0] w_r;
    logic [PW-1:0]     w_lhs;
    logic [PW-1:0]     w_rhs;
    logic              w_pri;
    logic              w_sec;
    logic              w_hit;

    assign oready   = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign w_accept = idata_en && oready;
    assign w_hs     = r_valid && ipeak_ready;
    assign w_eval   = (r_state == S_EMIT) && !r_scan_end
                   && (!r_valid || ipeak_ready);

    assign w_l_idx = (r_scan == '0) ? LAST : r_scan - IDX_W'(1);
    assign w_r_idx = (r_scan == LAST) ? '0 : r_scan + IDX_W'(1);
    assign w_c     = r_buf[r_scan];
    assign w_l     = r_buf[w_l_idx];
    assign w_r     = r_buf[w_r_idx];
    assign w_lhs   = PW'(w_c) * PW'(RATIO_DEN);
    assign w_rhs   = PW'(r_max_val) * PW'(RATIO_NUM);

    assign w_pri = (r_scan == r_max_idx) && (r_max_val != '0);
`ifdef PEAK_SECONDARY_EN
    assign w_sec = (r_scan != r_max_idx) && (w_c > w_l)
                && (w_c >= w_r) && (w_lhs >= w_rhs);
`else
    assign w_sec = 1'b0;
`endif
    assign w_hit = w_pri || w_sec;

    assign opeak_valid   = r_valid;
    assign opeak_index   = r_idx;
    assign opeak_value   = r_val;
    assign opeak_primary = r_pri;
    assign odone         = (r_state == S_DONE);
    assign opeak_count   = r_count;

    // Bin buffer and running maximum; lowest index wins a tie.
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            for (int k = 0; k < N_BINS; k++) r_buf[k] <= '0;
            r_max_val <= '0;
            r_max_idx <= '0;
        end else if (w_accept) begin
            r_buf[r_wr_idx] <= idata;
            if (r_wr_idx == '0 || idata > r_max_val) begin
                r_max_val <= idata;
                r_max_idx <= r_wr_idx;
            end
        end
    end

    // Control FSM, scan pointer and peak output register.
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            r_state    <= S_IDLE;
            r_wr_idx   <= '0;
            r_scan     <= '0;
            r_scan_end <= 1'b0;
            r_valid    <= 1'b0;
            r_idx      <= '0;
            r_val      <= '0;
            r_pri      <= 1'b0;
            r_count    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE, S_LOAD: begin
                    if (w_accept) begin
                        if (r_wr_idx == LAST) begin
                            r_wr_idx   <= '0;
                            r_scan     <= '0;
                            r_scan_end <= 1'b0;
                            r_state    <= S_EMIT;
                        end else begin
                            r_wr_idx <= r_wr_idx + IDX_W'(1);
                            r_state  <= S_LOAD;
                        end
                    end
                end
                S_EMIT: begin
                    if (w_hs) r_count <= r_count + IDX_W'(1);
                    if (w_eval) begin
                        if (w_hit) begin
                            r_valid <= 1'b1;
                            r_idx   <= r_scan;
                            r_val   <= w_c;
                            r_pri   <= w_pri;
                        end else if (w_hs) begin
                            r_valid <= 1'b0;
                        end
                        if (r_scan == LAST) r_scan_end <= 1'b1;
                        else r_scan <= r_scan + IDX_W'(1);
                    end else if (w_hs) begin
                        r_valid <= 1'b0;
                    end
                    if (r_scan_end && (!r_valid || w_hs))
                        r_state <= S_DONE;
                end
                S_DONE: begin
                    r_count <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
